irq_ctrl: RTL

Memory-mapped interrupt aggregator that sits directly downstream of the system tick timer and the other SoC peripherals. It collects the per-peripheral interrupt lines (the timer's intr_o on source 0), latches them as pending, and applies enable masking. It provides a claim/complete service and drives a single registered interrupt request to the RISC-V core. It is configured over the same AXI4-Lite-style cfg_* register port used by the peripherals.

---
 rtl/irq_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Brief    : Interrupt aggregator with pending/enable/mode registers,
//            claim/complete service and a registered request to the core.
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_awvalid_i,
    input  logic [31:0]        cfg_awaddr_i,
    input  logic               cfg_wvalid_i,
    input  logic [31:0]        cfg_wdata_i,
    input  logic [3:0]         cfg_wstrb_i,
    input  logic               cfg_bready_i,
    input  logic               cfg_arvalid_i,
    input  logic [31:0]        cfg_araddr_i,
    input  logic               cfg_rready_i,
    output logic               cfg_awready_o,
    output logic               cfg_wready_o,
    output logic               cfg_bvalid_o,
    output logic [1:0]         cfg_bresp_o,
    output logic               cfg_arready_o,
    output logic               cfg_rvalid_o,
    output logic [31:0]        cfg_rdata_o,
    output logic [1:0]         cfg_rresp_o,
    input  logic [NUM_SRC-1:0] irq_src_i,
    output logic               intr_o
);

    localparam logic [7:0] c_ADDR_RAW       = 8'h00;
    localparam logic [7:0] c_ADDR_PENDING   = 8'h04;
    localparam logic [7:0] c_ADDR_ENABLE    = 8'h08;
    localparam logic [7:0] c_ADDR_MODE      = 8'h0C;
    localparam logic [7:0] c_ADDR_CLAIM     = 8'h10;
    localparam logic [7:0] c_ADDR_FORCE     = 8'h14;
    localparam logic [7:0] c_ADDR_INSERVICE = 8'h18;

    logic [NUM_SRC-1:0] r_sync1, r_sync2, r_sync_d;
    logic [NUM_SRC-1:0] r_pending, r_enable, r_mode, r_inservice;
    logic               r_bvalid, r_rvalid, r_intr;
    logic [31:0]        r_rdata;

    logic               w_awready, w_wr, w_rd, w_claim;
    logic [7:0]         w_waddr, w_raddr;
    logic [NUM_SRC-1:0] w_wdata, w_edge, w_set, w_w1c, w_elig;
    logic [NUM_SRC-1:0] w_claim_oh, w_complete;
    logic [4:0]         w_claim_id;
    logic [31:0]        w_rdata_mux;
    logic               w_unused;

    assign w_awready = ~r_bvalid & ~cfg_arvalid_i;
    assign w_wr      = cfg_awvalid_i & cfg_wvalid_i & w_awready;
    assign w_rd      = cfg_arvalid_i & ~r_rvalid;
    assign w_waddr   = cfg_awaddr_i[7:0];
    assign w_raddr   = cfg_araddr_i[7:0];
    assign w_wdata   = cfg_wdata_i[NUM_SRC-1:0];
    assign w_unused  = ^{cfg_wstrb_i, cfg_awaddr_i[31:8], cfg_araddr_i[31:8]};

    assign w_edge = r_sync2 & ~r_sync_d;
    assign w_elig = r_pending & r_enable & ~r_inservice;

    // Scan from the top so the lowest-numbered eligible source wins.
    always_comb begin
        w_claim_id = '0;
        w_claim_oh = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_claim_id    = 5'(i + 1);
                w_claim_oh    = '0;
                w_claim_oh[i] = 1'b1;
            end
        end
    end

    assign w_claim = w_rd && (w_raddr == c_ADDR_CLAIM) && (w_claim_id != 5'd0);

    // Out-of-range ids match no source and therefore complete nothing.
    always_comb begin
        w_complete = '0;
        if (w_wr && (w_waddr == c_ADDR_CLAIM)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cfg_wdata_i == 32'(i + 1)) begin
                    w_complete[i] = 1'b1;
                end
            end
        end
    end

    assign w_set = (r_mode & w_edge) | (~r_mode & r_sync2)
                 | ((w_wr && (w_waddr == c_ADDR_FORCE)) ? w_wdata : '0);
    assign w_w1c = ((w_wr && (w_waddr == c_ADDR_PENDING)) ? w_wdata : '0)
                 | (w_claim ? w_claim_oh : '0);

    always_comb begin
        w_rdata_mux = '0;
        case (w_raddr)
            c_ADDR_RAW:       w_rdata_mux = 32'(r_sync2);
            c_ADDR_PENDING:   w_rdata_mux = 32'(r_pending);
            c_ADDR_ENABLE:    w_rdata_mux = 32'(r_enable);
            c_ADDR_MODE:      w_rdata_mux = 32'(r_mode);
            c_ADDR_CLAIM:     w_rdata_mux = 32'(w_claim_id);
            c_ADDR_INSERVICE: w_rdata_mux = 32'(r_inservice);
            default:          w_rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_sync_d    <= '0;
            r_pending   <= '0;
            r_enable    <= '0;
            r_mode      <= '0;
            r_inservice <= '0;
            r_bvalid    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_intr      <= 1'b0;
        end else begin
            r_sync1     <= irq_src_i;
            r_sync2     <= r_sync1;
            r_sync_d    <= r_sync2;
            r_pending   <= (r_pending & ~w_w1c) | w_set;
            r_inservice <= (r_inservice & ~w_complete) | (w_claim ? w_claim_oh : '0);
            r_intr      <= |w_elig;
            if (w_wr && (w_waddr == c_ADDR_ENABLE)) begin
                r_enable <= w_wdata;
            end
            if (w_wr && (w_waddr == c_ADDR_MODE)) begin
                r_mode <= w_wdata;
            end
            if (w_wr) begin
                r_bvalid <= 1'b1;
            end else if (cfg_bready_i) begin
                r_bvalid <= 1'b0;
            end
            if (w_rd) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata_mux;
            end else if (cfg_rready_i) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign cfg_awready_o = w_awready;
    assign cfg_wready_o  = w_awready;
    assign cfg_bvalid_o  = r_bvalid;
    assign cfg_bresp_o   = 2'b00;
    assign cfg_arready_o = ~r_rvalid;
    assign cfg_rvalid_o  = r_rvalid;
    assign cfg_rdata_o   = r_rdata;
    assign cfg_rresp_o   = 2'b00;
    assign intr_o        = r_intr;

endmodule
`default_nettype wire
